// File: rtl/i2c_reg_seq_if.sv
// Client request/response port and I2C byte-engine command port
// used by the register-access sequencer.
interface reg_req_if #(
  parameter int REG_AW = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [6:0]        req_dev_addr;
  logic [REG_AW-1:0] req_reg_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_rw, req_dev_addr,
    output req_reg_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_rw, req_dev_addr,
    input  req_reg_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface i2c_cmd_if;
  logic [2:0] m_cmd;
  logic [7:0] m_din;
  logic       m_wr_i2c;
  logic       m_ready;
  logic       m_done_tick;
  logic       m_ack;
  logic [7:0] m_dout;

  modport master (
    output m_cmd, m_din, m_wr_i2c,
    input  m_ready, m_done_tick, m_ack, m_dout
  );

  modport slave (
    input  m_cmd, m_din, m_wr_i2c,
    output m_ready, m_done_tick, m_ack, m_dout
  );
endinterface

// File: rtl/i2c_reg_seq.sv
// I2C register-access sequencer: expands one write/read request
// into START..STOP engine commands and returns one response.
module i2c_reg_seq #(
  parameter int REG_ADDR_BYTES = 1,
  parameter int REG_AW = 8 * REG_ADDR_BYTES
) (
  input logic   clk,
  input logic   reset_n,
  reg_req_if.slave req,
  i2c_cmd_if.master m
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_LO, WAIT_RDY, RESP
  } state_t;

  localparam logic [2:0] C_START = 3'b000;
  localparam logic [2:0] C_WR    = 3'b001;
  localparam logic [2:0] C_RD    = 3'b010;
  localparam logic [2:0] C_STOP  = 3'b011;
  localparam logic [2:0] C_RS    = 3'b100;

  // last register-address step index
  localparam logic [2:0] REG_END = 3'(REG_ADDR_BYTES + 1);

  state_t state, state_n;

  logic [2:0]        step;
  logic              rw_q;
  logic [6:0]        dev_q;
  logic [REG_AW-1:0] reg_q;
  logic [7:0]        wd_q;
  logic [7:0]        rd_q;
  logic              err_q;
  logic              up_q;

  logic s_start, s_dev, s_reg, s_data;
  logic s_rs, s_dev1, s_rd, s_stop, s_wbyte;
  logic [2:0] stop_step;
  logic [2:0] cmd;
  logic [7:0] din;
  logic wr, accept, done;
  logic unused;

  assign unused = m.m_done_tick;

  always_comb begin
    s_start   = step == 3'd0;
    s_dev     = step == 3'd1;
    s_reg     = step >= 3'd2 && step <= REG_END;
    s_data    = !rw_q && step == REG_END + 3'd1;
    s_rs      = rw_q && step == REG_END + 3'd1;
    s_dev1    = rw_q && step == REG_END + 3'd2;
    s_rd      = rw_q && step == REG_END + 3'd3;
    stop_step = rw_q ? REG_END + 3'd4
                     : REG_END + 3'd2;
    s_stop    = step == stop_step;
    s_wbyte   = s_dev | s_reg | s_data | s_dev1;
  end

  // reg_q shifts left per sent byte, so its top byte is next
  always_comb begin
    cmd = C_STOP;
    din = 8'h00;
    unique case (1'b1)
      s_start: cmd = C_START;
      s_dev: begin
        cmd = C_WR;
        din = {dev_q, 1'b0};
      end
      s_reg: begin
        cmd = C_WR;
        din = reg_q[REG_AW-1 -: 8];
      end
      s_data: begin
        cmd = C_WR;
        din = wd_q;
      end
      s_rs: cmd = C_RS;
      s_dev1: begin
        cmd = C_WR;
        din = {dev_q, 1'b1};
      end
      s_rd: begin
        cmd = C_RD;
        din = 8'h01;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    wr      = 1'b0;
    accept  = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req.req_valid && up_q) begin
          accept  = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        wr = m.m_ready;
        if (m.m_ready) state_n = WAIT_LO;
      end
      WAIT_LO: state_n = WAIT_RDY;
      WAIT_RDY: begin
        if (m.m_ready) begin
          done    = 1'b1;
          state_n = s_stop ? RESP : ISSUE;
        end
      end
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_q  <= 1'b0;
      step  <= 3'd0;
      rw_q  <= 1'b0;
      dev_q <= 7'h00;
      reg_q <= '0;
      wd_q  <= 8'h00;
      rd_q  <= 8'h00;
      err_q <= 1'b0;
    end else begin
      up_q <= 1'b1;
      if (accept) begin
        step  <= 3'd0;
        rw_q  <= req.req_rw;
        dev_q <= req.req_dev_addr;
        reg_q <= req.req_reg_addr;
        wd_q  <= req.req_wdata;
        rd_q  <= 8'h00;
        err_q <= 1'b0;
      end else if (done && !s_stop) begin
        if (s_wbyte && m.m_ack) begin
          err_q <= 1'b1;
          step  <= stop_step;
        end else begin
          step <= step + 3'd1;
          if (s_reg) reg_q <= reg_q << 8;
          if (s_rd)  rd_q  <= m.m_dout;
        end
      end
    end
  end

  assign req.req_ready = state == IDLE && up_q;
  assign req.rsp_valid = state == RESP;
  assign req.rsp_err   = state == RESP && err_q;
  assign req.rsp_rdata =
    (state == RESP && !err_q) ? rd_q : 8'h00;

  assign m.m_wr_i2c = wr;
  assign m.m_cmd = state == ISSUE ? cmd : C_START;
  assign m.m_din = state == ISSUE ? din : 8'h00;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// Bench for i2c_reg_seq: 1- and 2-byte register-address instances
// driven against a scripted engine, checked by a sequence model.
module tb_i2c_reg_seq;

  localparam logic [2:0] C_START = 3'b000;
  localparam logic [2:0] C_WR    = 3'b001;
  localparam logic [2:0] C_RD    = 3'b010;
  localparam logic [2:0] C_STOP  = 3'b011;
  localparam logic [2:0] C_RS    = 3'b100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_rw    [2];
  logic [6:0]  req_dev   [2];
  logic [15:0] req_reg   [2];
  logic [7:0]  req_wd    [2];
  logic        stall     [2];
  logic        nack_en   [2];
  logic [7:0]  nack_byte [2];
  logic [7:0]  rd_byte   [2];

  logic       o_ready  [2];
  logic       o_rvalid [2];
  logic       o_rerr   [2];
  logic       o_wr     [2];
  logic       o_mready [2];
  logic [7:0] o_rdata  [2];
  logic [7:0] o_din    [2];
  logic [2:0] o_cmd    [2];

  for (genvar g = 0; g < 2; g++) begin : dut
    localparam int NB = g + 1;
    localparam int AW = 8 * NB;

    reg_req_if #(.REG_AW(AW)) rq();
    i2c_cmd_if mc();

    logic       rdy, done, ack;
    logic [7:0] dout, ldin;
    logic [2:0] lcmd;
    int         cnt;

    i2c_reg_seq #(.REG_ADDR_BYTES(NB)) u (
      .clk(clk),
      .reset_n(reset_n),
      .req(rq),
      .m(mc)
    );

    assign rq.req_valid    = req_valid[g];
    assign rq.req_rw       = req_rw[g];
    assign rq.req_dev_addr = req_dev[g];
    assign rq.req_reg_addr = req_reg[g][AW-1:0];
    assign rq.req_wdata    = req_wd[g];

    assign mc.m_ready     = rdy && !stall[g];
    assign mc.m_done_tick = done;
    assign mc.m_ack       = ack;
    assign mc.m_dout      = dout;

    assign o_ready[g]  = rq.req_ready;
    assign o_rvalid[g] = rq.rsp_valid;
    assign o_rerr[g]   = rq.rsp_err;
    assign o_rdata[g]  = rq.rsp_rdata;
    assign o_wr[g]     = mc.m_wr_i2c;
    assign o_cmd[g]    = mc.m_cmd;
    assign o_din[g]    = mc.m_din;
    assign o_mready[g] = mc.m_ready;

    // engine: busy for a few cycles per byte, then hold
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rdy  <= 1'b1;
        done <= 1'b0;
        ack  <= 1'b1;
        dout <= 8'h00;
        cnt  <= 0;
        lcmd <= 3'b000;
        ldin <= 8'h00;
      end else begin
        done <= 1'b0;
        if (mc.m_wr_i2c && rdy && !stall[g]) begin
          rdy  <= 1'b0;
          cnt  <= 1 + g;
          lcmd <= mc.m_cmd;
          ldin <= mc.m_din;
        end else if (!rdy) begin
          if (cnt == 0) begin
            rdy  <= 1'b1;
            done <= 1'b1;
            ack  <= (lcmd == C_WR)
                    ? (nack_en[g] && ldin == nack_byte[g])
                    : 1'b1;
            dout <= (lcmd == C_RD) ? rd_byte[g] : 8'hEE;
          end else begin
            cnt <= cnt - 1;
          end
        end
      end
    end
  end

  int checks = 0;
  int passed = 0;

  logic [10:0] expq [2][$];
  int          outst  [2];
  int          age_tx [2];
  logic [7:0]  exp_rd [2];
  logic        exp_err[2];
  int          rst_age = 0;
  bit          pinned = 1'b0;
  logic [10:0] scr [$];
  logic [10:0] lit [$];
  logic        scr_err;

  function automatic string nm(int g, string s);
    return $sformatf("d%0d_%s", g, s);
  endfunction

  function automatic void check(string s, logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", s, act, exp);
  endfunction

  function automatic void flag(string s);
    checks++;
    $display("FAIL %s: event not allowed here", s);
  endfunction

  // expected command list: START, bytes until a NACK, STOP
  function automatic void build(int nb, logic rw, logic [6:0] dev,
                                logic [15:0] ra, logic [7:0] wd,
                                logic ne, logic [7:0] nk);
    logic [10:0] plan [$];
    plan = {};
    plan.push_back({C_WR, dev, 1'b0});
    for (int i = nb - 1; i >= 0; i--)
      plan.push_back({C_WR, ra[8*i +: 8]});
    if (rw) begin
      plan.push_back({C_RS, 8'h00});
      plan.push_back({C_WR, dev, 1'b1});
      plan.push_back({C_RD, 8'h01});
    end else begin
      plan.push_back({C_WR, wd});
    end
    scr = {};
    scr_err = 1'b0;
    scr.push_back({C_START, 8'h00});
    foreach (plan[i]) begin
      if (!scr_err) begin
        scr.push_back(plan[i]);
        if (plan[i][10:8] == C_WR && ne && plan[i][7:0] == nk)
          scr_err = 1'b1;
      end
    end
    scr.push_back({C_STOP, 8'h00});
  endfunction

  function automatic void pin(string s, logic e);
    bit ok;
    ok = (scr.size() == lit.size()) && (scr_err == e);
    if (ok) foreach (lit[i]) if (scr[i] !== lit[i]) ok = 1'b0;
    checks++;
    if (ok) passed++;
    else $display("FAIL pin_%s: got %0d steps err %0b expected %0d steps err %0b",
                  s, scr.size(), scr_err, lit.size(), e);
  endfunction

  always @(negedge clk) begin
    if (!pinned) begin
      pinned = 1'b1;
      build(1, 0, 7'h50, 16'h0010, 8'hA5, 0, 8'h00);
      lit = '{11'h000, 11'h1A0, 11'h110, 11'h1A5, 11'h300};
      pin("wr1", 1'b0);
      build(1, 1, 7'h50, 16'h0010, 8'h00, 0, 8'h00);
      lit = '{11'h000, 11'h1A0, 11'h110, 11'h400,
              11'h1A1, 11'h201, 11'h300};
      pin("rd1", 1'b0);
      build(1, 0, 7'h51, 16'h0010, 8'hA5, 1, 8'hA2);
      lit = '{11'h000, 11'h1A2, 11'h300};
      pin("nack_dev", 1'b1);
      build(2, 0, 7'h50, 16'h1234, 8'h77, 0, 8'h00);
      lit = '{11'h000, 11'h1A0, 11'h112, 11'h134,
              11'h177, 11'h300};
      pin("wr2", 1'b0);
      build(2, 0, 7'h50, 16'h1234, 8'h77, 1, 8'h34);
      lit = '{11'h000, 11'h1A0, 11'h112, 11'h134, 11'h300};
      pin("nack_reg", 1'b1);
    end
    for (int g = 0; g < 2; g++) begin
      if (!reset_n) begin
        check(nm(g, "reset_outs"),
              32'({o_ready[g], o_rvalid[g], o_rerr[g], o_wr[g],
                   o_rdata[g], o_cmd[g], o_din[g]}), 32'h0);
        expq[g] = {};
        outst[g] = 0;
      end else begin
        check(nm(g, "req_ready"), 32'(o_ready[g]),
              32'(rst_age >= 1 && outst[g] == 0));
        if (o_wr[g]) begin
          check(nm(g, "strobe_rdy"), 32'(o_mready[g]), 32'h1);
          if (expq[g].size() == 0) begin
            flag(nm(g, "strobe_extra"));
          end else begin
            logic [10:0] e;
            logic [10:0] a;
            e = expq[g].pop_front();
            a = (e[10:8] == C_WR || e[10:8] == C_RD)
                ? {o_cmd[g], o_din[g]} : {o_cmd[g], 8'h00};
            check(nm(g, "strobe"), 32'(a), 32'(e));
          end
        end
        if (o_rvalid[g]) begin
          if (outst[g] == 0) begin
            flag(nm(g, "rsp_extra"));
          end else begin
            check(nm(g, "rsp"), 32'({o_rerr[g], o_rdata[g]}),
                  32'({exp_err[g], exp_rd[g]}));
            check(nm(g, "rsp_steps_left"),
                  32'(expq[g].size()), 32'h0);
            outst[g] = 0;
          end
        end else if (outst[g] > 0) begin
          age_tx[g]++;
          if (age_tx[g] > 400) begin
            flag(nm(g, "timeout"));
            outst[g] = 0;
            expq[g] = {};
          end
        end
        if (req_valid[g] && o_ready[g]) begin
          build(g + 1, req_rw[g], req_dev[g], req_reg[g],
                req_wd[g], nack_en[g], nack_byte[g]);
          expq[g] = scr;
          exp_err[g] = scr_err;
          exp_rd[g] = (req_rw[g] && !scr_err) ? rd_byte[g] : 8'h00;
          outst[g] = 1;
          age_tx[g] = 0;
        end
      end
    end
    if (!reset_n) rst_age = 0;
    else rst_age++;
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(int g);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (o_ready[g]) break;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(int g);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (o_rvalid[g]) break;
    end
    cyc(1);
  endtask

  task automatic cfg(int g, logic ne, logic [7:0] nk,
                     logic [7:0] rb);
    nack_en[g] = ne;
    nack_byte[g] = nk;
    rd_byte[g] = rb;
  endtask

  task automatic send(int g, logic rw, logic [6:0] dev,
                      logic [15:0] ra, logic [7:0] wd);
    req_rw[g] = rw;
    req_dev[g] = dev;
    req_reg[g] = ra;
    req_wd[g] = wd;
    req_valid[g] = 1'b1;
    wait_accept(g);
    req_valid[g] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0;
      req_rw[g] = 1'b0;
      req_dev[g] = 7'h00;
      req_reg[g] = 16'h0000;
      req_wd[g] = 8'h00;
      stall[g] = 1'b0;
      cfg(g, 1'b0, 8'h00, 8'h00);
    end
    cyc(3);
    reset_n = 1'b1;
    cyc(2);

    cfg(0, 1'b0, 8'h00, 8'h3C);
    send(0, 1'b0, 7'h50, 16'h0010, 8'hA5);
    wait_rsp(0);
    send(0, 1'b1, 7'h50, 16'h0010, 8'h00);
    wait_rsp(0);
    cfg(0, 1'b1, 8'hA2, 8'h3C);
    send(0, 1'b0, 7'h51, 16'h0010, 8'hA5);
    wait_rsp(0);
    send(0, 1'b1, 7'h51, 16'h0020, 8'h00);
    wait_rsp(0);

    cfg(1, 1'b0, 8'h00, 8'h5A);
    send(1, 1'b0, 7'h50, 16'h1234, 8'h77);
    wait_rsp(1);
    cfg(1, 1'b1, 8'h34, 8'h5A);
    send(1, 1'b0, 7'h50, 16'h1234, 8'h77);
    wait_rsp(1);
    send(1, 1'b1, 7'h2B, 16'hBEEF, 8'h00);
    wait_rsp(1);
    cfg(1, 1'b1, 8'h57, 8'h5A);
    send(1, 1'b1, 7'h2B, 16'hBEEF, 8'h00);
    wait_rsp(1);

    // valid held high: second request waits for the first response
    cfg(0, 1'b0, 8'h00, 8'hC3);
    req_rw[0] = 1'b0;
    req_dev[0] = 7'h22;
    req_reg[0] = 16'h0081;
    req_wd[0] = 8'h5E;
    req_valid[0] = 1'b1;
    wait_accept(0);
    req_rw[0] = 1'b1;
    req_dev[0] = 7'h23;
    req_reg[0] = 16'h0042;
    wait_accept(0);
    req_valid[0] = 1'b0;
    wait_rsp(0);

    // engine held busy before the first command
    stall[0] = 1'b1;
    send(0, 1'b0, 7'h10, 16'h00F0, 8'h0F);
    cyc(6);
    stall[0] = 1'b0;
    wait_rsp(0);

    // reset while the register-address byte is in flight
    send(0, 1'b0, 7'h50, 16'h0010, 8'h11);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_wr[0] && o_cmd[0] == C_WR && o_din[0] == 8'h10) break;
    end
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    send(0, 1'b0, 7'h50, 16'h0033, 8'h99);
    wait_rsp(0);

    cyc(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
